trace_uart_tx: RTL
==================

TRACE_UART_TX -- requirements
Module: trace_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868: clk cycles per UART bit (115200 baud at 100 MHz); legal range 2 or more.
REQ-002 SHALL have parameter DECIM, default 1048576: clk cycles between sample ticks; legal range 2 or more.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port go, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port I1_int, input, 16 bits: integer part of I (state block output I1[31:16]).
REQ-006 SHALL have port R1_int, input, 16 bits: integer part of R (R1[31:16]).
REQ-007 SHALL have port Pt1_int, input, 16 bits: integer part of p(t) (Pt[31:16]).
REQ-008 SHALL have port tx, output, 1 bit: UART 8N1 serial line; idles high.
REQ-009 SHALL have port busy, output, 1 bit: high while a frame is on the line.
REQ-010 SHALL have port drop_cnt, output, 8 bits: count of sample ticks dropped because a frame was still in progress.

Function
REQ-011 SHALL run a decimation counter that counts 0 to DECIM-1 and wraps; a tick occurs in the cycle where the counter equals DECIM-1. The first tick is therefore DECIM cycles after go deasserts.
REQ-012 SHALL, on a tick while IDLE, latch I1_int, R1_int and Pt1_int into a snapshot on that same edge. Inputs are not sampled at any other time.
REQ-013 SHALL, on a tick while a frame is in progress, discard the sample and increment drop_cnt, saturating at 255.
REQ-014 SHALL transmit an 8-byte frame in this order: 0xA5, I hi, I lo, R hi, R lo, Pt hi, Pt lo, CHK. CHK is the XOR of the six data bytes.
REQ-015 SHALL send each byte as 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1); each bit lasts exactly CLKS_PER_BIT cycles.
REQ-016 SHALL send bytes back-to-back with no idle gap; a frame lasts exactly 80*CLKS_PER_BIT cycles.
REQ-017 SHALL have a registered tx output; tx goes low on the first edge after the tick cycle.
REQ-018 SHALL assert busy on the same edge that tx first goes low, and deassert it on the edge that ends the last stop bit.
REQ-019 SHALL use the FSM states IDLE, START, DATA, STOP, with these transitions:
- IDLE to START on a tick.
- START to DATA after 1 bit period.
- DATA to STOP after 8 bit periods.
- STOP to START if the byte index is below 7, otherwise to IDLE.
REQ-020 SHALL accept a tick that coincides with the final cycle of a STOP on the byte-7 boundary as a drop, since the state is still STOP.
REQ-021 SHALL keep the snapshot stable for the whole frame; input changes during a frame do not alter the transmitted bytes.

Reset
REQ-022 SHALL, while go is high, drive tx=1, busy=0, drop_cnt=0, state=IDLE, and clear the decimation counter, the bit counter, the byte index and the snapshot.
REQ-023 SHALL abort any frame in progress when go asserts mid-frame, with tx high on the next edge; no partial byte completes.

Structure
REQ-024 SHALL place the following in shared package trace_pkg: the sync byte constant 0xA5, the frame length constant 8, and the FSM state typedef.
REQ-025 SHALL place the byte serializer (START/DATA/STOP timing, bit counter, shift register) in sub-module uart_tx_byte. It has a load/ready handshake and is driven by the frame sequencer in trace_uart_tx.

Verification
All scenarios use CLKS_PER_BIT=4.
REQ-026 SHALL cover the nominal frame: DECIM=400, I1_int=0x000A, R1_int=0x2134, Pt1_int=0x0400.
- Required line bytes: A5 00 0A 21 34 04 00 1B.
- busy is high for 320 cycles; drop_cnt=0.
REQ-027 SHALL cover drops: DECIM=200.
- First frame starts after the tick at cycle 199.
- The tick at cycle 399 is dropped, so drop_cnt=1.
- The tick at cycle 599 starts a new frame.
REQ-028 SHALL cover saturation: DECIM=2 for 2000 cycles. Required: drop_cnt reaches 255 and holds at 255.
REQ-029 SHALL cover reset mid-frame: assert go for 1 cycle during the DATA bits of byte 3.
- Next edge: tx=1, busy=0, drop_cnt=0.
- The next frame starts DECIM cycles after go deasserts.
REQ-030 SHALL cover snapshot hold: DECIM=400; change all inputs to 0xFFFF one cycle after the tick. Required: the frame still carries the original values and CHK=0x1B.
REQ-031 SHALL cover bit timing: measure every tx edge in a frame. Required: all edge spacings are multiples of 4 cycles, and the start bit is 4 cycles wide.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared constants and types for the trace UART frame transmitter.
// Frame layout: SYNC, I hi, I lo, R hi, R lo, Pt hi, Pt lo, CHK.
package trace_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         FRAME_LEN = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // XOR of the six payload bytes
  function automatic logic [7:0] frame_chk(input logic [15:0] i_val,
                                           input logic [15:0] r_val,
                                           input logic [15:0] p_val);
    return i_val[15:8] ^ i_val[7:0] ^ r_val[15:8] ^ r_val[7:0] ^
           p_val[15:8] ^ p_val[7:0];
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer with a registered tx line and a load/ready handshake.
module uart_tx_byte
  import trace_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      load,
  input  logic [7:0] data,
  output logic      ready,
  output logic      tx,
  output tx_state_t state
);

  // Handshake: a byte is taken on any edge where load && ready. ready is high
  // in IDLE and in the final cycle of STOP, so the next byte follows the stop
  // bit with no idle gap. load while ready is low is ignored.
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  tx_state_t state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;
  logic          bit_last;

  assign bit_last = (bit_cnt_q == CW'(CLKS_PER_BIT - 1));
  assign ready    = (state_q == IDLE) || ((state_q == STOP) && bit_last);
  assign tx       = tx_q;
  assign state    = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      tx_q      <= tx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_last ? '0 : bit_cnt_q + CW'(1);
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    tx_d      = tx_q;
    unique case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (load) begin
          state_d = START;
          shreg_d = data;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_last) begin
          state_d   = DATA;
          bit_idx_d = '0;
          tx_d      = shreg_q[0];
        end
      end
      DATA: begin
        if (bit_last) begin
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shreg_d   = {1'b0, shreg_q[7:1]};
            tx_d      = shreg_q[1];
          end
        end
      end
      STOP: begin
        if (bit_last) begin
          if (load) begin
            state_d = START;
            shreg_d = data;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/trace_uart_tx.sv
// Periodic trace sampler: every DECIM cycles snapshot I/R/Pt and send them as
// an 8-byte UART frame; ticks arriving mid-frame are counted as drops.
module trace_uart_tx
  import trace_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DECIM        = 1048576
) (
  input  logic        clk,
  input  logic        go,
  input  logic [15:0] I1_int,
  input  logic [15:0] R1_int,
  input  logic [15:0] Pt1_int,
  output logic        tx,
  output logic        busy,
  output logic [7:0]  drop_cnt,
  output tx_state_t   dbg_state
);

  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [DW-1:0] dec_cnt;
  logic [2:0]    byte_idx;
  logic [15:0]   snap_i, snap_r, snap_p;
  logic [7:0]    drop_q;
  logic          tick, start, drop, advance, load;
  logic [2:0]    load_idx;
  logic [7:0]    load_byte;
  logic          ser_ready;
  tx_state_t     ser_state;

  assign tick     = (dec_cnt == DW'(DECIM - 1));
  assign start    = tick && (ser_state == IDLE);
  assign drop     = tick && (ser_state != IDLE);
  // ready inside STOP marks the last stop-bit cycle of the current byte
  assign advance  = (ser_state == STOP) && ser_ready &&
                    (byte_idx != 3'(FRAME_LEN - 1));
  assign load     = start || advance;
  assign load_idx = start ? 3'd0 : byte_idx + 3'd1;

  // Byte 0 is constant, so the snapshot latched on the start edge is in
  // place before byte 1 is requested.
  always_comb begin
    load_byte = SYNC_BYTE;
    case (load_idx)
      3'd1:    load_byte = snap_i[15:8];
      3'd2:    load_byte = snap_i[7:0];
      3'd3:    load_byte = snap_r[15:8];
      3'd4:    load_byte = snap_r[7:0];
      3'd5:    load_byte = snap_p[15:8];
      3'd6:    load_byte = snap_p[7:0];
      3'd7:    load_byte = frame_chk(snap_i, snap_r, snap_p);
      default: load_byte = SYNC_BYTE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (go) begin
      dec_cnt  <= '0;
      byte_idx <= '0;
      snap_i   <= '0;
      snap_r   <= '0;
      snap_p   <= '0;
      drop_q   <= '0;
    end else begin
      dec_cnt <= tick ? '0 : dec_cnt + DW'(1);
      if (start) begin
        snap_i   <= I1_int;
        snap_r   <= R1_int;
        snap_p   <= Pt1_int;
        byte_idx <= '0;
      end else if (advance) begin
        byte_idx <= byte_idx + 3'd1;
      end
      if (drop && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
    end
  end

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
    .clk  (clk),
    .rst  (go),
    .load (load),
    .data (load_byte),
    .ready(ser_ready),
    .tx   (tx),
    .state(ser_state)
  );

  assign busy      = (ser_state != IDLE);
  assign drop_cnt  = drop_q;
  assign dbg_state = ser_state;

endmodule
